alu_cmd_parser: RTL and testbench
=================================

Name: alu_cmd_parser

Overview:
Upstream stage of the UART calculator datapath. It consumes ASCII bytes from the UART receiver and parses commands of the form "<dec> <op> <dec> <term>". It drives the ALU's num1, num2 and oper inputs and holds them stable. It pulses cmd_valid when a well-formed command is complete, or err with a cause code otherwise.

Parameters:
TERM_CHAR, 8'h3D ('='), primary command terminator
ALT_TERM, 8'h0D (CR), secondary command terminator

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_data  input  8  received ASCII byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte; back-to-back cycles allowed
num1  output  8  first operand to ALU, registered, held until next accepted command
num2  output  8  second operand to ALU, registered, held
oper  output  4  ALU opcode, registered, held
cmd_valid  output  1  one-cycle pulse: num1/num2/oper updated with new command
err  output  1  one-cycle pulse: command rejected
err_code  output  2  cause, valid only with err: 00 syntax, 01 bad char, 10 overflow, 11 divide-by-zero

Behaviour:
- Reset (async, active-high): num1=0, num2=0, oper=4'b0000, cmd_valid=0, err=0, err_code=00, state=S_NUM1, accumulator=0, digit flag=0. Reset mid-command discards the partial command.
- Bytes are processed only on edges where rx_valid=1; when rx_valid=0, state, accumulator and all outputs are held.
- Character classes:
  - digit 0x30-0x39
  - operator '+'(0x2B)->0000, '-'(0x2D)->0001, '*'(0x2A)->0010, '/'(0x2F)->0100 (quotient), '%'(0x25)->1000 (remainder)
  - terminator TERM_CHAR or ALT_TERM
  - space 0x20, ignored in every state
  - LF 0x0A, ignored in every state
  - anything else: bad char
- States:
  - S_NUM1
    - digit: acc=acc*10+d, set digit flag.
    - operator with digit flag set: store acc as pending num1, latch pending opcode, clear acc and flag, go S_NUM2.
    - operator with digit flag clear: syntax error.
    - terminator with no digits: ignored (empty line).
    - terminator with digits: syntax error.
  - S_NUM2
    - digit: accumulates as in S_NUM1.
    - terminator with digit flag set: command complete.
    - terminator with digit flag clear: syntax error.
    - operator: syntax error.
  - S_ERR
    - Discards every byte until a terminator, then goes to S_NUM1 with acc and flag cleared.
    - No further err pulses while in S_ERR.
- Overflow: the acc*10+d product is computed at 12 bits or wider. A result >255 raises err_code 10; enter S_ERR. Leading zeros are legal ("007" = 7).
- Error: err=1 with err_code for exactly one cycle, on the edge after the offending byte is sampled. Go S_ERR, except a syntax error raised on a terminator, which returns directly to S_NUM1. num1, num2 and oper keep their previous values.
- Command complete:
  - If the pending opcode is 0100 or 1000 and the second operand is 0: err_code 11, no update, go S_NUM1.
  - Otherwise, on the edge after the terminator is sampled, load num1/num2/oper and pulse cmd_valid for one cycle; go S_NUM1.
  - cmd_valid and err are never asserted together.
- Latency: terminator sampled at edge N -> cmd_valid high during cycle N..N+1. The ALU result is valid combinationally in that same cycle.
- Products >255 are not an error here; the ALU truncates to 8 bits.

Test Plan:
- Bytes "12+34=" -> one cmd_valid pulse the cycle after '='; num1=12, num2=34, oper=0000; err never asserted.
- Bytes "200 * 3\r" (spaces included, CR terminator) -> num1=200, num2=3, oper=0010, cmd_valid pulse; ALU out=8'd88.
- Bytes "256+1=" then "9%4=" -> err with code 10 the cycle after '6'; remaining "+1=" produces no pulse; then num1=9, num2=4, oper=1000, cmd_valid.
- Bytes "7/0=" -> err with code 11, no cmd_valid; outputs retain the previous command's values.
- Bytes "+5=", "5x3=", "5-=" -> err codes 00, 01, 00 respectively; the "5x3=" case recovers only at '='.
- Bytes "45-" then rst pulse mid-stream, then "8-9=" -> all outputs 0 during reset; then num1=8, num2=9, oper=0001, cmd_valid, with no residue of the discarded 45.

Source files
------------

// File: rtl/alu_cmd_parser_if.sv
// Byte stream in, ALU operands out, between the UART receiver and the ALU.
// rx_valid is a one-cycle strobe with no ready: the parser accepts every byte.
interface alu_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [3:0] oper;
    logic       cmd_valid;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output rx_data, rx_valid,
        input  num1, num2, oper, cmd_valid, err, err_code
    );

    modport slave (
        input  rx_data, rx_valid,
        output num1, num2, oper, cmd_valid, err, err_code
    );
endinterface

// File: rtl/alu_cmd_parser.sv
// Parses "<dec> <op> <dec> <term>" ASCII commands into registered ALU operands,
// pulsing cmd_valid on a good command or err with a cause code otherwise.
module alu_cmd_parser #(
    parameter logic [7:0] TERM_CHAR = 8'h3D,
    parameter logic [7:0] ALT_TERM  = 8'h0D
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_parser_if.slave  bus,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_NUM1 = 2'd0,
        S_NUM2 = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] E_SYNTAX = 2'b00;
    localparam logic [1:0] E_BADCHR = 2'b01;
    localparam logic [1:0] E_OVFL   = 2'b10;
    localparam logic [1:0] E_DIV0   = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic        dig_q, dig_d;
    logic [7:0]  pend_num1_q, pend_num1_d;
    logic [3:0]  pend_op_q, pend_op_d;
    logic [7:0]  num1_q, num1_d;
    logic [7:0]  num2_q, num2_d;
    logic [3:0]  oper_q, oper_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        is_digit, is_term, is_skip, is_op;
    logic [3:0]  op_code;
    logic [11:0] acc_wide;
    logic        acc_ovfl;
    logic        div_by_zero;

    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_term  = (bus.rx_data == TERM_CHAR) || (bus.rx_data == ALT_TERM);
    assign is_skip  = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0A);

    // Low nibble of an ASCII digit is its value; 255*10+9 fits in 12 bits.
    assign acc_wide = ({4'b0000, acc_q} * 12'd10) + {8'b0000_0000, bus.rx_data[3:0]};
    assign acc_ovfl = (acc_wide > 12'd255);
    assign div_by_zero = ((pend_op_q == 4'b0100) || (pend_op_q == 4'b1000)) && (acc_q == 8'd0);

    always_comb begin
        is_op   = 1'b1;
        op_code = 4'b0000;
        case (bus.rx_data)
            8'h2B:   op_code = 4'b0000;
            8'h2D:   op_code = 4'b0001;
            8'h2A:   op_code = 4'b0010;
            8'h2F:   op_code = 4'b0100;
            8'h25:   op_code = 4'b1000;
            default: is_op   = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        dig_d       = dig_q;
        pend_num1_d = pend_num1_q;
        pend_op_d   = pend_op_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        oper_d      = oper_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;

        if (bus.rx_valid && !is_skip) begin
            unique case (state_q)
                S_NUM1, S_NUM2: begin
                    if (is_digit) begin
                        if (acc_ovfl) begin
                            err_d      = 1'b1;
                            err_code_d = E_OVFL;
                            state_d    = S_ERR;
                            acc_d      = 8'd0;
                            dig_d      = 1'b0;
                        end else begin
                            acc_d = acc_wide[7:0];
                            dig_d = 1'b1;
                        end
                    end else if (is_op) begin
                        if (state_q == S_NUM1 && dig_q) begin
                            pend_num1_d = acc_q;
                            pend_op_d   = op_code;
                            acc_d       = 8'd0;
                            dig_d       = 1'b0;
                            state_d     = S_NUM2;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = E_SYNTAX;
                            state_d    = S_ERR;
                            acc_d      = 8'd0;
                            dig_d      = 1'b0;
                        end
                    end else if (is_term) begin
                        // A bare terminator in S_NUM1 is an empty line and is ignored.
                        if (state_q == S_NUM2 || dig_q) begin
                            state_d = S_NUM1;
                            acc_d   = 8'd0;
                            dig_d   = 1'b0;
                            if (state_q == S_NUM1 || !dig_q) begin
                                err_d      = 1'b1;
                                err_code_d = E_SYNTAX;
                            end else if (div_by_zero) begin
                                err_d      = 1'b1;
                                err_code_d = E_DIV0;
                            end else begin
                                num1_d      = pend_num1_q;
                                num2_d      = acc_q;
                                oper_d      = pend_op_q;
                                cmd_valid_d = 1'b1;
                            end
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = E_BADCHR;
                        state_d    = S_ERR;
                        acc_d      = 8'd0;
                        dig_d      = 1'b0;
                    end
                end
                default: begin
                    if (is_term) begin
                        state_d = S_NUM1;
                        acc_d   = 8'd0;
                        dig_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_NUM1;
            acc_q       <= 8'd0;
            dig_q       <= 1'b0;
            pend_num1_q <= 8'd0;
            pend_op_q   <= 4'b0000;
            num1_q      <= 8'd0;
            num2_q      <= 8'd0;
            oper_q      <= 4'b0000;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            dig_q       <= dig_d;
            pend_num1_q <= pend_num1_d;
            pend_op_q   <= pend_op_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            oper_q      <= oper_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.num1      = num1_q;
    assign bus.num2      = num2_q;
    assign bus.oper      = oper_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Directed and random command lines checked byte-by-byte against a
// line-oriented reference parser working on plain integers.
module tb_alu_cmd_parser;
    typedef logic [23:0] word_t;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    alu_cmd_parser_if bus ();

    alu_cmd_parser dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    word_t      exp_q[$];
    logic [7:0] line_q[$];
    word_t      last_exp;
    logic [7:0] m_num1, m_num2;
    logic [3:0] m_oper;
    int         n_checks;
    int         n_fail;

    function automatic word_t observed();
        return {bus.cmd_valid, bus.err, (bus.err ? bus.err_code : 2'b00),
                bus.num1, bus.num2, bus.oper};
    endfunction

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] op_of(input logic [7:0] c);
        case (c)
            8'h2B:   return 4'b0000;
            8'h2D:   return 4'b0001;
            8'h2A:   return 4'b0010;
            8'h2F:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    // Reference parser: one line at a time, first fault kills the rest of the line.
    task automatic model_line();
        int         phase = 0;
        int         cur = 0;
        int         n1 = 0;
        bit         dig = 0;
        bit         dead = 0;
        logic [3:0] op = 4'b0000;
        foreach (line_q[i]) begin
            logic [7:0] c;
            bit         cv;
            bit         e;
            logic [1:0] code;
            c = line_q[i];
            cv = 0;
            e = 0;
            code = 2'b00;
            if (!dead) begin
                if (c == 8'h20 || c == 8'h0A) begin
                end else if (c >= 8'h30 && c <= 8'h39) begin
                    cur = cur * 10 + (int'(c) - 48);
                    dig = 1;
                    if (cur > 255) begin e = 1; code = 2'b10; dead = 1; end
                end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F || c == 8'h25) begin
                    if (phase == 0 && dig) begin
                        phase = 1; op = op_of(c); n1 = cur; cur = 0; dig = 0;
                    end else begin
                        e = 1; code = 2'b00; dead = 1;
                    end
                end else if (c == 8'h3D || c == 8'h0D) begin
                    if (phase == 0 && !dig) begin
                    end else if (phase == 0 || !dig) begin
                        e = 1; code = 2'b00;
                    end else if ((op == 4'b0100 || op == 4'b1000) && cur == 0) begin
                        e = 1; code = 2'b11;
                    end else begin
                        cv = 1; m_num1 = 8'(n1); m_num2 = 8'(cur); m_oper = op;
                    end
                    phase = 0; cur = 0; dig = 0;
                end else begin
                    e = 1; code = 2'b01; dead = 1;
                end
            end
            exp_q.push_back({cv, e, code, m_num1, m_num2, m_oper});
        end
    endtask

    // driver: one byte per cycle with random idle gaps
    task automatic drive_line();
        foreach (line_q[i]) begin
            word_t exp;
            bus.rx_data  = line_q[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_valid = 1'b0;
            exp = exp_q.pop_front();
            check($sformatf("byte%0d_%h", i, line_q[i]), observed(), exp);
            last_exp = exp;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("idle_hold", observed(), {4'b0000, last_exp[19:0]});
            end
        end
    endtask

    task automatic run_str(input string s);
        line_q.delete();
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
        model_line();
        drive_line();
    endtask

    task automatic push_num(input int v);
        logic [7:0] tmp[$];
        if (v == 0) tmp.push_back(8'h30);
        while (v > 0) begin
            tmp.push_front(8'(8'h30 + v % 10));
            v = v / 10;
        end
        if ($urandom_range(0, 7) == 0) tmp.push_front(8'h30);
        foreach (tmp[i]) line_q.push_back(tmp[i]);
    endtask

    task automatic gen_line();
        logic [7:0] ops[5] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h25};
        logic [7:0] bad[3] = '{8'h78, 8'h41, 8'h21};
        int k;
        line_q.delete();
        k = $urandom_range(0, 19);
        if ($urandom_range(0, 5) == 0) line_q.push_back(8'h0A);
        if (k != 0) begin
            if (k != 1) push_num(($urandom_range(0, 9) == 0) ? $urandom_range(256, 400) : $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) line_q.push_back(8'h20);
            if (k == 2) line_q.push_back(bad[$urandom_range(0, 2)]);
            else line_q.push_back(ops[$urandom_range(0, 4)]);
            if (k == 4) line_q.push_back(ops[$urandom_range(0, 4)]);
            if ($urandom_range(0, 1) == 1) line_q.push_back(8'h20);
            if (k != 3) begin
                if ($urandom_range(0, 5) == 0) push_num(0);
                else push_num(($urandom_range(0, 9) == 0) ? $urandom_range(256, 400) : $urandom_range(0, 255));
            end
        end
        line_q.push_back(($urandom_range(0, 1) == 1) ? 8'h3D : 8'h0D);
        model_line();
        drive_line();
    endtask

    initial begin
        logic [7:0] prod;
        n_checks = 0;
        n_fail   = 0;
        m_num1 = 8'd0; m_num2 = 8'd0; m_oper = 4'b0000;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", observed(), 24'h0);
        check("reset_state", {22'd0, state_dbg}, 24'd0);
        rst = 1'b0;
        @(negedge clk);

        run_str("12+34=");
        check("add_operands", {4'b0, bus.num1, bus.num2, bus.oper}, {4'b0, 8'd12, 8'd34, 4'b0000});

        run_str("200 * 3\r");
        prod = bus.num1 * bus.num2;
        check("mul_operands", {4'b0, bus.num1, bus.num2, bus.oper}, {4'b0, 8'd200, 8'd3, 4'b0010});
        check("mul_truncated", {16'd0, prod}, {16'd0, 8'd88});

        run_str("256+1=");
        run_str("9%4=");
        check("rem_operands", {4'b0, bus.num1, bus.num2, bus.oper}, {4'b0, 8'd9, 8'd4, 4'b1000});

        run_str("7/0=");
        check("div0_retained", {4'b0, bus.num1, bus.num2, bus.oper}, {4'b0, 8'd9, 8'd4, 4'b1000});

        run_str("+5=");
        run_str("5x3=");
        run_str("5-=");
        run_str("=");
        run_str("007+255\n=");
        run_str("12=");
        run_str("25*26=");

        // partial command, then asynchronous reset between clock edges
        run_str("45-");
        #2 rst = 1'b1;
        m_num1 = 8'd0; m_num2 = 8'd0; m_oper = 4'b0000;
        #1 check("async_reset", observed(), 24'h0);
        @(negedge clk);
        check("reset_hold", observed(), 24'h0);
        rst = 1'b0;
        @(negedge clk);
        run_str("8-9=");
        check("after_reset", {4'b0, bus.num1, bus.num2, bus.oper}, {4'b0, 8'd8, 8'd9, 4'b0001});

        for (int n = 0; n < 60; n++) gen_line();

        check("queue_drained", {8'd0, 16'(exp_q.size())}, 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
